// File: rtl/press_gen_pkg.sv
// Shared types and constants for the synthetic button-press generator.
// Holds the FSM state type and the LFSR geometry (x^10 + x^7 + 1).
package press_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PRESS = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int                LFSR_W    = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;
  localparam int                TAP_HI    = 9;
  localparam int                TAP_LO    = 6;

  // Fibonacci step: shift left, feed back bit 9 ^ bit 6 into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/press_gen_lfsr.sv
// Free-running 10-bit maximal-length LFSR; advances every cycle, never all-zero.
// Latency: q updates one cycle after each rising edge. Backpressure: none (free-running).
// Reset: async active-low, loads the fixed nonzero seed.
module lfsr10
  import press_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= LFSR_SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/press_gen.sv
// Synthetic button-press generator: random pulses of PRESS_LEN cycles spaced by GAP_LEN+.
// Latency: press rises the cycle after the hitting tick. Backpressure: none; enable only
// gates new pulses. Optional PRESS_GEN_CNT_EN adds a saturating 8-bit pulse counter.
module press_gen
  import press_gen_pkg::*;
#(
  parameter int TICK_DIV  = 1024,
  parameter int PRESS_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] level,
`ifdef PRESS_GEN_CNT_EN
  output logic [7:0] press_count,
`endif
  output logic       press
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  PRESS_LD  = 8'(PRESS_LEN - 1);
  localparam logic [7:0]  GAP_LD    = 8'(GAP_LEN - 1);

  state_t             state, state_nxt;
  logic [15:0]        presc, presc_nxt;
  logic [7:0]         dcnt, dcnt_nxt;
  logic               tick;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               lfsr_unused;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[LFSR_W-1:4];
  assign tick        = (state == WAIT) && (presc == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      presc <= 16'd0;
      dcnt  <= 8'd0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      dcnt  <= dcnt_nxt;
      press <= (state_nxt == PRESS);
    end
  end

  // Duration counter is loaded with LEN-1 on entry and the phase ends when it reads 0.
  always_comb begin
    state_nxt = state;
    presc_nxt = 16'd0;
    dcnt_nxt  = 8'd0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (lfsr_q[3:0] < level) begin
            state_nxt = PRESS;
            dcnt_nxt  = PRESS_LD;
          end
        end else begin
          presc_nxt = presc + 16'd1;
        end
      end
      PRESS: begin
        if (dcnt == 8'd0) begin
          state_nxt = GAP;
          dcnt_nxt  = GAP_LD;
        end else begin
          dcnt_nxt  = dcnt - 8'd1;
        end
      end
      GAP: begin
        if (dcnt == 8'd0) state_nxt = enable ? WAIT : IDLE;
        else              dcnt_nxt  = dcnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PRESS_GEN_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_count <= 8'd0;
    end else if (state != PRESS && state_nxt == PRESS && press_count != 8'hFF) begin
      press_count <= press_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_press_gen.sv
// Directed/table bench for press_gen with TICK_DIV=PRESS_LEN=GAP_LEN=4.
module tb_press_gen;
  import press_gen_pkg::*;

  localparam int TD = 4;
  localparam int PL = 4;
  localparam int GL = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] level  = 4'd0;
  logic       press;
`ifdef PRESS_GEN_CNT_EN
  logic [7:0] press_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  press_gen #(.TICK_DIV(TD), .PRESS_LEN(PL), .GAP_LEN(GL)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .level       (level),
`ifdef PRESS_GEN_CNT_EN
    .press_count (press_count),
`endif
    .press       (press)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting, 2 pressing, 3 gap; ctr counts up in
  // waiting and holds the remaining cycles in pressing/gap.
  logic [9:0] m_lfsr;
  int         m_mode;
  int         m_ctr;

  task automatic model_reset();
    m_lfsr = 10'h001;
    m_mode = 0;
    m_ctr  = 0;
  endtask

  task automatic model_step();
    case (m_mode)
      0: if (enable) begin m_mode = 1; m_ctr = 0; end
      1: begin
        if (!enable) m_mode = 0;
        else if (m_ctr == TD - 1) begin
          if (int'(m_lfsr[3:0]) < int'(level)) begin m_mode = 2; m_ctr = PL; end
          else m_ctr = 0;
        end else m_ctr++;
      end
      2: begin
        m_ctr--;
        if (m_ctr == 0) begin m_mode = 3; m_ctr = GL; end
      end
      default: begin
        m_ctr--;
        if (m_ctr == 0) begin m_mode = enable ? 1 : 0; m_ctr = 0; end
      end
    endcase
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    level  = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0] lvl;
    int         edges;
    logic       exp_press;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, pulses, gap, guard;
    logic prev;

    // Press value after N edges from reset release with enable=1 and constant level.
    // First tick sees lfsr[3:0]=0 (after 4 edges), second tick sees 4 (after 16 edges).
    tbl[0]  = '{4'd1,  4,  1'b0};
    tbl[1]  = '{4'd1,  5,  1'b1};
    tbl[2]  = '{4'd0,  5,  1'b0};
    tbl[3]  = '{4'd1,  8,  1'b1};
    tbl[4]  = '{4'd1,  9,  1'b0};
    tbl[5]  = '{4'd1,  12, 1'b0};
    tbl[6]  = '{4'd5,  17, 1'b1};
    tbl[7]  = '{4'd4,  17, 1'b0};
    tbl[8]  = '{4'd15, 17, 1'b1};
    tbl[9]  = '{4'd15, 20, 1'b1};
    tbl[10] = '{4'd15, 21, 1'b0};
    tbl[11] = '{4'd0,  17, 1'b0};

    do_reset();
    check("reset_press", 32'(press), 32'd0);
    check("reset_lfsr", 32'(dut.u_lfsr.q), 32'h001);
    check("reset_state", 32'(dut.state), 32'(IDLE));

    for (int i = 0; i < 12; i++) begin
      do_reset();
      enable = 1'b1;
      level  = tbl[i].lvl;
      repeat (tbl[i].edges) step();
      check($sformatf("tbl%0d_press", i), 32'(press), 32'(tbl[i].exp_press));
    end

    // Level only matters in the tick cycle.
    do_reset();
    enable = 1'b1;
    repeat (4) step();
    level = 4'd1;
    step();
    level = 4'd0;
    check("level_in_tick_hits", 32'(press), 32'd1);

    do_reset();
    enable = 1'b1;
    level  = 4'd15;
    repeat (4) step();
    level = 4'd0;
    step();
    level = 4'd15;
    check("level_zero_in_tick_misses", 32'(press), 32'd0);

    // Asynchronous reset during a pulse.
    do_reset();
    enable = 1'b1;
    level  = 4'd15;
    repeat (6) step();
    check("pre_reset_press", 32'(press), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_press", 32'(press), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    enable = 1'b0;
    check("post_reset_lfsr", 32'(dut.u_lfsr.q), 32'h001);
    check("post_reset_state", 32'(dut.state), 32'(IDLE));
    step();
    check("idle_holds", 32'(dut.state), 32'(IDLE));

    // Zero level never presses.
    do_reset();
    enable = 1'b1;
    hi = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (press) hi++;
    end
    check("zero_level_high_cycles", 32'(hi), 32'd0);

    // Max level: pulse widths and spacing.
    do_reset();
    enable = 1'b1;
    level  = 4'd15;
    prev = 1'b0; hi = 0; lo = 0; pulses = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (press && !prev) begin
        if (pulses > 0) check("max_low_interval_ge8", 32'(lo >= PL + GL), 32'd1);
        pulses++;
        hi = 0;
      end
      if (!press && prev) begin
        check("max_pulse_width", 32'(hi), 32'(PL));
        lo = 0;
      end
      if (press) hi++; else lo++;
      prev = press;
    end
    check("max_pulse_count_ge20", 32'(pulses >= 20), 32'd1);

    // Enable dropped in the second PRESS cycle.
    do_reset();
    enable = 1'b1;
    level  = 4'd15;
    guard  = 0;
    while (!press && guard < 50) begin step(); guard++; end
    check("drop_found_pulse", 32'(press), 32'd1);
    hi = 1;
    step();
    if (press) hi++;
    enable = 1'b0;
    guard = 0;
    while (press && guard < 20) begin step(); hi++; guard++; end
    hi = press ? hi : hi - 1;
    check("drop_pulse_width", 32'(hi), 32'(PL));
    gap = 0;
    guard = 0;
    while (dut.state == GAP && guard < 20) begin gap++; step(); guard++; end
    check("drop_gap_len", 32'(gap), 32'(GL));
    check("drop_state_idle", 32'(dut.state), 32'(IDLE));
    hi = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (press) hi++;
    end
    check("drop_no_more_pulses", 32'(hi), 32'd0);

    // Golden model, level 8, with a short enable outage.
    do_reset();
    enable = 1'b1;
    level  = 4'd8;
    prev = 1'b0; pulses = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) enable = 1'b0;
      if (c == 1010) enable = 1'b1;
      step();
      check($sformatf("golden_c%0d", c), 32'(press), 32'(m_mode == 2));
      if (press && !prev) pulses++;
      prev = press;
    end
    check("golden_pulse_count_ge20", 32'(pulses >= 20), 32'd1);

`ifdef PRESS_GEN_CNT_EN
    do_reset();
    check("cnt_reset", 32'(press_count), 32'd0);
    enable = 1'b1;
    level  = 4'd15;
    prev = 1'b0; pulses = 0; guard = 0;
    while (pulses < 3 && guard < 200) begin
      step();
      if (press && !prev) pulses++;
      prev = press;
      guard++;
    end
    check("cnt_three", 32'(press_count), 32'd3);
    guard = 0;
    while (pulses < 300 && guard < 8000) begin
      step();
      if (press && !prev) pulses++;
      prev = press;
      guard++;
    end
    check("cnt_pulses_300", 32'(pulses), 32'd300);
    check("cnt_saturated", 32'(press_count), 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
